// File: rtl/mse_topk_sorter_if.sv
// rtl/mse_topk_sorter_if.sv - MSE sample input stream and ranked result output stream
// master drives samples and consumes results; slave is the sorter side.
interface mse_topk_sorter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_W     = 8,
  parameter int RANK_W     = 2
);
  logic                  mse_in_valid;
  logic                  mse_in_ready;
  logic [WORD_WIDTH-1:0] mse_in_value;
  logic [ADDR_W-1:0]     mse_in_ref;
  logic                  mse_in_last;

  logic                  mse_out_valid;
  logic                  mse_out_ready;
  logic [WORD_WIDTH-1:0] mse_out_value;
  logic [ADDR_W-1:0]     mse_out_ref;
  logic [RANK_W-1:0]     mse_out_rank;
  logic                  mse_out_last;

  modport master (
    output mse_in_valid, mse_in_value, mse_in_ref, mse_in_last, mse_out_ready,
    input  mse_in_ready, mse_out_valid, mse_out_value, mse_out_ref, mse_out_rank, mse_out_last
  );

  modport slave (
    input  mse_in_valid, mse_in_value, mse_in_ref, mse_in_last, mse_out_ready,
    output mse_in_ready, mse_out_valid, mse_out_value, mse_out_ref, mse_out_rank, mse_out_last
  );
endinterface

// File: rtl/mse_topk_sorter.sv
// rtl/mse_topk_sorter.sv - keeps the TOP_K smallest MSE results of a sweep and drains them ranked
// Optional running-maximum tracker enabled by MSE_TOPK_MAX_TRACK_EN.
module mse_topk_sorter #(
  parameter int WORD_WIDTH            = 32,
  parameter int HSI_LIBRARY_SIZE      = 256,
  parameter int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE),
  parameter int TOP_K                 = 4,
  parameter int RANK_W                = $clog2(TOP_K)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  mse_topk_sorter_if.slave                 bus,
  output logic [WORD_WIDTH-1:0]            mse_max_value,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_max_ref
);

  typedef enum logic {COLLECT, DRAIN} state_e;

  state_e                           state_q, state_d;
  logic [RANK_W-1:0]                idx_q, idx_d;
  logic [TOP_K-1:0]                 vld_q, vld_d;
  logic [WORD_WIDTH-1:0]            val_q [TOP_K];
  logic [WORD_WIDTH-1:0]            val_d [TOP_K];
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] ref_q [TOP_K];
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] ref_d [TOP_K];

  logic                             in_ready_q;
  logic                             out_valid_q;
  logic [WORD_WIDTH-1:0]            out_value_q, out_value_d;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] out_ref_q, out_ref_d;
  logic [RANK_W-1:0]                out_rank_q, out_rank_d;
  logic                             out_last_q, out_last_d;

  logic [TOP_K-1:0]                 gt;
  logic [RANK_W-1:0]                last_idx;
  logic                             accept;
  logic                             out_hs;

  assign accept = (state_q == COLLECT) && bus.mse_in_valid;
  assign out_hs = (state_q == DRAIN) && bus.mse_out_ready;

  // gt is monotonic over a sorted contiguous table, so its first set bit is the insert slot.
  always_comb begin
    for (int i = 0; i < TOP_K; i++) begin
      gt[i] = !vld_q[i] || (val_q[i] > bus.mse_in_value);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    val_d   = val_q;
    ref_d   = ref_q;

    if (clear) begin
      state_d = COLLECT;
      idx_d   = '0;
      vld_d   = '0;
    end else if (accept) begin
      if (gt[0]) begin
        val_d[0] = bus.mse_in_value;
        ref_d[0] = bus.mse_in_ref;
        vld_d[0] = 1'b1;
      end
      for (int i = 1; i < TOP_K; i++) begin
        if (gt[i]) begin
          if (gt[i-1]) begin
            val_d[i] = val_q[i-1];
            ref_d[i] = ref_q[i-1];
            vld_d[i] = vld_q[i-1];
          end else begin
            val_d[i] = bus.mse_in_value;
            ref_d[i] = bus.mse_in_ref;
            vld_d[i] = 1'b1;
          end
        end
      end
      if (bus.mse_in_last) begin
        state_d = DRAIN;
        idx_d   = '0;
      end
    end else if (out_hs) begin
      if (out_last_q) begin
        state_d = COLLECT;
        idx_d   = '0;
        vld_d   = '0;
      end else begin
        idx_d = idx_q + RANK_W'(1);
      end
    end
  end

  // Output registers are loaded from next-state so they are valid on the same edge DRAIN begins.
  always_comb begin
    last_idx = '0;
    for (int i = 0; i < TOP_K; i++) begin
      if (vld_d[i]) last_idx = RANK_W'(i);
    end
    out_value_d = '0;
    out_ref_d   = '0;
    out_rank_d  = '0;
    out_last_d  = 1'b0;
    if (state_d == DRAIN) begin
      out_value_d = val_d[idx_d];
      out_ref_d   = ref_d[idx_d];
      out_rank_d  = idx_d;
      out_last_d  = (idx_d == last_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      vld_q       <= '0;
      for (int i = 0; i < TOP_K; i++) begin
        val_q[i] <= '0;
        ref_q[i] <= '0;
      end
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_ref_q   <= '0;
      out_rank_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vld_q       <= vld_d;
      val_q       <= val_d;
      ref_q       <= ref_d;
      in_ready_q  <= (state_d == COLLECT);
      out_valid_q <= (state_d == DRAIN);
      out_value_q <= out_value_d;
      out_ref_q   <= out_ref_d;
      out_rank_q  <= out_rank_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.mse_in_ready  = in_ready_q;
  assign bus.mse_out_valid = out_valid_q;
  assign bus.mse_out_value = out_value_q;
  assign bus.mse_out_ref   = out_ref_q;
  assign bus.mse_out_rank  = out_rank_q;
  assign bus.mse_out_last  = out_last_q;

`ifdef MSE_TOPK_MAX_TRACK_EN
  logic [WORD_WIDTH-1:0]            run_val_q, run_val_d;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] run_ref_q, run_ref_d;
  logic                             run_any_q, run_any_d;
  logic [WORD_WIDTH-1:0]            max_val_q, max_val_d;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] max_ref_q, max_ref_d;

  // >= lets the latest reference win ties; the published max is cleared on a sweep's first accept.
  always_comb begin
    run_val_d = run_val_q;
    run_ref_d = run_ref_q;
    run_any_d = run_any_q;
    max_val_d = max_val_q;
    max_ref_d = max_ref_q;
    if (clear) begin
      run_val_d = '0;
      run_ref_d = '0;
      run_any_d = 1'b0;
      max_val_d = '0;
      max_ref_d = '0;
    end else if (accept) begin
      if (!run_any_q || (bus.mse_in_value >= run_val_q)) begin
        run_val_d = bus.mse_in_value;
        run_ref_d = bus.mse_in_ref;
      end
      if (bus.mse_in_last) begin
        max_val_d = run_val_d;
        max_ref_d = run_ref_d;
        run_any_d = 1'b0;
      end else begin
        if (!run_any_q) begin
          max_val_d = '0;
          max_ref_d = '0;
        end
        run_any_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_val_q <= '0;
      run_ref_q <= '0;
      run_any_q <= 1'b0;
      max_val_q <= '0;
      max_ref_q <= '0;
    end else begin
      run_val_q <= run_val_d;
      run_ref_q <= run_ref_d;
      run_any_q <= run_any_d;
      max_val_q <= max_val_d;
      max_ref_q <= max_ref_d;
    end
  end

  assign mse_max_value = max_val_q;
  assign mse_max_ref   = max_ref_q;
`else
  assign mse_max_value = '0;
  assign mse_max_ref   = '0;
`endif

endmodule

// File: tb/tb_mse_topk_sorter.sv
// tb/tb_mse_topk_sorter.sv - directed bench for mse_topk_sorter with a sort-based reference model
// Define MSE_TOPK_MAX_TRACK_EN to exercise the max tracker.
module tb_mse_topk_sorter;
  localparam int W = 32;
  localparam int A = 8;
  localparam int K = 4;
  localparam int R = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         clear = 1'b0;
  logic [W-1:0] max_value;
  logic [A-1:0] max_ref;

  mse_topk_sorter_if #(.WORD_WIDTH(W), .ADDR_W(A), .RANK_W(R)) bus ();

  mse_topk_sorter #(
    .WORD_WIDTH(W), .HSI_LIBRARY_SIZE(256), .TOP_K(K)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .mse_max_value(max_value), .mse_max_ref(max_ref)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { longint v; longint r; } ent_t;
  typedef struct { longint v; longint r; int rank; bit last; int c; } hs_t;

  ent_t   acc[$];
  ent_t   lst[$];
  hs_t    hs_log[$];
  bit     m_drain = 1'b0;
  int     m_idx = 0;
  int     m_acc_cyc = 0;
  bit     m_run_any = 1'b0;
  longint m_run_v = 0, m_run_r = 0, m_max_v = 0, m_max_r = 0;

  // Stable selection of the K smallest: strict < keeps the earliest of equal values first.
  task automatic build_list();
    bit used [64];
    int best;
    for (int j = 0; j < 64; j++) used[j] = 1'b0;
    lst.delete();
    for (int k = 0; k < K && k < acc.size(); k++) begin
      best = -1;
      for (int j = 0; j < acc.size(); j++)
        if (!used[j] && (best < 0 || acc[j].v < acc[best].v)) best = j;
      used[best] = 1'b1;
      lst.push_back(acc[best]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      acc.delete(); lst.delete();
      m_drain = 1'b0; m_idx = 0; m_run_any = 1'b0; m_max_v = 0; m_max_r = 0;
      chk("rst_in_ready", bus.mse_in_ready, 1);
      chk("rst_out_valid", bus.mse_out_valid, 0);
      chk("rst_out_value", bus.mse_out_value, 0);
      chk("rst_out_ref", bus.mse_out_ref, 0);
      chk("rst_out_rank", bus.mse_out_rank, 0);
      chk("rst_out_last", bus.mse_out_last, 0);
      chk("rst_max_value", max_value, 0);
      chk("rst_max_ref", max_ref, 0);
    end else begin
      chk("in_ready", bus.mse_in_ready, !m_drain);
      chk("out_valid", bus.mse_out_valid, m_drain);
      if (m_drain) begin
        chk("out_value", bus.mse_out_value, lst[m_idx].v);
        chk("out_ref", bus.mse_out_ref, lst[m_idx].r);
        chk("out_rank", bus.mse_out_rank, m_idx);
        chk("out_last", bus.mse_out_last, m_idx == lst.size() - 1);
      end
      chk("max_value", max_value, m_max_v);
      chk("max_ref", max_ref, m_max_r);

      if (clear) begin
        acc.delete();
        m_drain = 1'b0; m_idx = 0; m_run_any = 1'b0; m_max_v = 0; m_max_r = 0;
      end else if (!m_drain && bus.mse_in_valid) begin
        acc.push_back('{v: bus.mse_in_value, r: bus.mse_in_ref});
`ifdef MSE_TOPK_MAX_TRACK_EN
        if (!m_run_any || bus.mse_in_value >= m_run_v) begin
          m_run_v = bus.mse_in_value;
          m_run_r = bus.mse_in_ref;
        end
        if (bus.mse_in_last) begin
          m_max_v = m_run_v; m_max_r = m_run_r; m_run_any = 1'b0;
        end else begin
          if (!m_run_any) begin m_max_v = 0; m_max_r = 0; end
          m_run_any = 1'b1;
        end
`endif
        if (bus.mse_in_last) begin
          build_list();
          acc.delete();
          m_drain = 1'b1; m_idx = 0; m_acc_cyc = cyc;
        end
      end else if (m_drain && bus.mse_out_ready) begin
        hs_log.push_back('{v: bus.mse_out_value, r: bus.mse_out_ref,
                           rank: bus.mse_out_rank, last: bus.mse_out_last, c: cyc});
        if (m_idx == lst.size() - 1) m_drain = 1'b0;
        else m_idx++;
      end
    end
  end

  task automatic send(input longint v, input longint r, input bit last);
    bus.mse_in_valid = 1'b1;
    bus.mse_in_value = W'(v);
    bus.mse_in_ref   = A'(r);
    bus.mse_in_last  = last;
    @(posedge clk); #1;
    bus.mse_in_valid = 1'b0;
    bus.mse_in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.mse_in_ready && !bus.mse_out_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", n < 40, 1);
  endtask

  task automatic exp_hs(input int i, input longint v, input longint r, input int rank, input bit last);
    if (i >= hs_log.size()) chk("hs_missing", hs_log.size(), i + 1);
    else begin
      chk("lit_value", hs_log[i].v, v);
      chk("lit_ref", hs_log[i].r, r);
      chk("lit_rank", hs_log[i].rank, rank);
      chk("lit_last", hs_log[i].last, last);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.mse_in_valid  = 1'b0;
    bus.mse_in_value  = '0;
    bus.mse_in_ref    = '0;
    bus.mse_in_last   = 1'b0;
    bus.mse_out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_in_ready", bus.mse_in_ready, 1);
    chk("init_out_valid", bus.mse_out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Five samples into a four-deep table with a tie on 20.
    hs_log.delete();
    send(50, 0, 0); send(20, 1, 0); send(80, 2, 0); send(20, 3, 0); send(10, 4, 1);
    wait_idle();
    chk("t1_count", hs_log.size(), 4);
    exp_hs(0, 10, 4, 0, 0); exp_hs(1, 20, 1, 1, 0); exp_hs(2, 20, 3, 2, 0); exp_hs(3, 50, 0, 3, 1);
    if (hs_log.size() == 4) begin
      chk("t1_first_hs_cycle", hs_log[0].c, m_acc_cyc + 1);
      for (int i = 1; i < 4; i++) chk("t1_consecutive", hs_log[i].c, hs_log[0].c + i);
    end

    // Two-sample sweep.
    hs_log.delete();
    send(7, 9, 0); send(3, 2, 1);
    wait_idle();
    chk("t2_count", hs_log.size(), 2);
    exp_hs(0, 3, 2, 0, 0); exp_hs(1, 7, 9, 1, 1);

    // Backpressure 1,0,0,1 with input offered while not ready.
    hs_log.delete();
    bus.mse_out_ready = 1'b0;
    send(30, 1, 0); send(15, 2, 0); send(60, 3, 1);
    bus.mse_out_ready = 1'b1;
    bus.mse_in_valid = 1'b1; bus.mse_in_value = 1; bus.mse_in_ref = 7; bus.mse_in_last = 1'b1;
    @(posedge clk); #1;
    bus.mse_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("t3_stall_rank", bus.mse_out_rank, 1);
    chk("t3_stall_value", bus.mse_out_value, 30);
    @(posedge clk); #1;
    chk("t3_stall_hold", bus.mse_out_value, 30);
    bus.mse_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_in_ready_low", bus.mse_in_ready, 0);
    bus.mse_in_valid = 1'b0; bus.mse_in_last = 1'b0;
    wait_idle();
    chk("t3_count", hs_log.size(), 3);
    exp_hs(0, 15, 2, 0, 0); exp_hs(1, 30, 1, 1, 0); exp_hs(2, 60, 3, 2, 1);

    // clear coincident with an accepted last sample.
    send(40, 0, 0);
    bus.mse_in_valid = 1'b1; bus.mse_in_value = 2; bus.mse_in_ref = 1; bus.mse_in_last = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; bus.mse_in_valid = 1'b0; bus.mse_in_last = 1'b0;
    chk("t4_no_drain", bus.mse_out_valid, 0);
    hs_log.delete();
    send(5, 6, 1);
    wait_idle();
    chk("t4_count", hs_log.size(), 1);
    exp_hs(0, 5, 6, 0, 1);

    // Asynchronous reset mid-drain after rank 1 has been taken.
    hs_log.delete();
    send(11, 0, 0); send(12, 1, 0); send(13, 2, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_pre_rank", bus.mse_out_rank, 2);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_out_valid", bus.mse_out_valid, 0);
    chk("t5_rst_in_ready", bus.mse_in_ready, 1);
    chk("t5_rst_out_value", bus.mse_out_value, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Max tracker: ties resolved toward the latest reference.
    hs_log.delete();
    send(4, 0, 0); send(9, 1, 0); send(9, 2, 0); send(1, 3, 1);
`ifdef MSE_TOPK_MAX_TRACK_EN
    chk("t6_max_value", max_value, 9);
    chk("t6_max_ref", max_ref, 2);
`else
    chk("t6_max_value", max_value, 0);
    chk("t6_max_ref", max_ref, 0);
`endif
    wait_idle();
    chk("t6_count", hs_log.size(), 4);
    exp_hs(0, 1, 3, 0, 0); exp_hs(1, 4, 0, 1, 0); exp_hs(2, 9, 1, 2, 0); exp_hs(3, 9, 2, 3, 1);

    // All-equal sweep longer than the table keeps the earliest references.
    hs_log.delete();
    for (int i = 0; i < 6; i++) send(5, i, i == 5);
    wait_idle();
    chk("t7_count", hs_log.size(), 4);
    exp_hs(0, 5, 0, 0, 0); exp_hs(3, 5, 3, 3, 1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mse_topk_sorter.md
# mse_topk_sorter

Parametrised successor to the single min/max MSE comparator. Tracks the `TOP_K` smallest MSE results, with their library references, across one pixel's sweep of the HSI library, held as an ascending sorted table. After the frame's last sample it streams the ranked list out over a valid/ready handshake. Sits between the MSE datapath and the classification result writer.

## Interface
- `WORD_WIDTH`, 32, MSE value width
- `HSI_LIBRARY_SIZE`, 256, number of library references
- `HSI_LIBRARY_SIZE_ADDR`, `$clog2(HSI_LIBRARY_SIZE)`, reference width
- `TOP_K`, 4, table depth; legal range 2..16
- `RANK_W`, `$clog2(TOP_K)`, rank index width

Ports, in the form name, direction, width, meaning:
- `clk`, in, 1, clock
- `rst_n`, in, 1, asynchronous active-low reset
- `clear`, in, 1, synchronous flush; returns the block to COLLECT with an empty table
- `mse_in_valid`, in, 1, input sample valid
- `mse_in_ready`, out, 1, block accepts input
- `mse_in_value`, in, WORD_WIDTH, MSE value
- `mse_in_ref`, in, HSI_LIBRARY_SIZE_ADDR, library reference
- `mse_in_last`, in, 1, final sample of the sweep
- `mse_out_valid`, out, 1, ranked result valid
- `mse_out_ready`, in, 1, downstream accepts result
- `mse_out_value`, out, WORD_WIDTH, MSE of current rank
- `mse_out_ref`, out, HSI_LIBRARY_SIZE_ADDR, reference of current rank
- `mse_out_rank`, out, RANK_W, 0 = best
- `mse_out_last`, out, 1, final ranked entry
- `mse_max_value`, out, WORD_WIDTH, worst MSE of the sweep (see Configuration)
- `mse_max_ref`, out, HSI_LIBRARY_SIZE_ADDR, reference of the worst MSE

## Operation
- The table holds `TOP_K` entries: value, ref, and a valid bit. Valid entries are contiguous from slot 0 and sorted ascending.
- States:
  - COLLECT: `mse_in_ready`=1, `mse_out_valid`=0.
  - DRAIN: `mse_in_ready`=0, `mse_out_valid`=1.
- Accept occurs on `mse_in_valid & mse_in_ready`. The insert position is the first slot that is invalid or holds a value strictly greater than the input.
  - Entries at and above that slot shift up by one; the top entry is dropped.
  - If no such slot exists, the table is unchanged.
- Ties: an existing entry beats a new entry with an equal value, so the earliest reference wins.
- An accept with `mse_in_last`=1 inserts that sample, then the block enters DRAIN on the next cycle with the read index at 0.
- DRAIN outputs are slot[idx]: `mse_out_rank`=idx, and `mse_out_last`=1 when idx is the last valid slot.
  - The index advances on `mse_out_valid & mse_out_ready`.
  - The handshake on the last entry invalidates the table and returns the block to COLLECT.
- Entries drained per sweep = min(TOP_K, samples accepted); this is at least 1.
- `clear` has priority over accept and drain in the same cycle. It empties the table and resets the read index and the max tracker.
- Comparisons are unsigned, full WORD_WIDTH; there is no saturation.

## Timing
- Insertion is single cycle; the table is updated on the edge following the accept.
- `mse_in_last` accepted at edge N: `mse_out_valid`=1 from edge N+1.
- `mse_in_ready` falls at edge N+1.
- DRAIN throughput is one entry per cycle while `mse_out_ready`=1.
- Output stability: all outputs are registered. `mse_out_*` hold stable while `mse_out_valid & !mse_out_ready`.
- The last drain handshake at edge M gives `mse_in_ready`=1 from edge M+1. There is no bubble beyond that.
- Reset values:
  - state COLLECT, all table valid bits 0, read index 0.
  - `mse_in_ready`=1; `mse_out_valid`, `mse_out_last`, `mse_out_rank`, `mse_out_value`, `mse_out_ref`, `mse_max_value` and `mse_max_ref` all 0.
- Reset asserted mid-sweep or mid-drain: the block returns immediately to the reset state, and partial results are discarded.

## Configuration
- `MSE_TOPK_MAX_TRACK_EN` defined:
  - The block keeps a running maximum over accepted samples using `>=`, so the latest reference wins ties.
  - The maximum is captured into `mse_max_value`/`mse_max_ref` when the last sample is accepted.
  - These outputs are held through DRAIN and reset at the start of the next sweep's first accept.
- `MSE_TOPK_MAX_TRACK_EN` not defined: the ports exist but are tied to 0, and no max logic is built.

## Test plan
- TOP_K=4, sweep values 50,20,80,20,10 with refs 0..4, last on ref 4, `mse_out_ready`=1.
  - Drain: (10,r4,rank0), (20,r1), (20,r3), (50,r0).
  - `mse_out_last` on rank 3, and the drain completes in 4 consecutive cycles.
- Sweep of two samples, 7 (r9) then 3 (r2, last): exactly two entries, (3,r2) then (7,r9), with `mse_out_last` on rank 1.
- `mse_out_ready` toggled 1,0,0,1 during drain: the output is held stable while stalled, and `mse_in_valid` is ignored while `mse_in_ready`=0.
- `clear` asserted in the same cycle as an accepted last sample: no DRAIN follows, the table is empty, and the next sweep of single value 5 (last) drains (5,rank0,last).
- `rst_n` pulsed during DRAIN after rank 1: all outputs return to reset values and `mse_in_ready`=1.
- With `MSE_TOPK_MAX_TRACK_EN`, sweep 4,9,9,1 with refs 0..3: `mse_max_value`=9 and `mse_max_ref`=2. Without the macro, both read 0.
